// File: rtl/serial_eq_comparator_pkg.sv
// Shared types and sizing for the bit-serial equality comparator.
package serial_eq_comparator_pkg;

   localparam int WIDTH_DEF = 5;

   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_eq_comparator_if.sv
// Request/result bundle between a requester (master) and the comparator (slave).
interface serial_eq_comparator_if
   import serial_eq_comparator_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = idx_w(WIDTH)
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             eq;
   logic [IDX_W-1:0] first_diff;

   modport master (output start, a_in, b_in, input busy, done, eq, first_diff);
   modport slave  (input start, a_in, b_in, output busy, done, eq, first_diff);
endinterface

// File: rtl/serial_eq_comparator_bit_cmp.sv
// Single-bit equality cell; the serial scan reuses it once per clock.
module serial_bit_cmp (
   input  logic a,
   input  logic b,
   output logic bit_eq
);
   assign bit_eq = ~(a ^ b);
endmodule

// File: rtl/serial_eq_comparator.sv
// Bit-serial A==B compare, LSB first, fixed WIDTH+2 cycles per request.
// Reports equality and lowest mismatching index; starts while busy are dropped.
module serial_eq_comparator
   import serial_eq_comparator_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = idx_w(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_eq_comparator_if.slave bus
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             acc_q, acc_d;
   logic             found_q, found_d;
   logic             eq_q, eq_d;
   logic [IDX_W-1:0] fd_q, fd_d;
   logic             done_q, done_d;
   logic             bit_eq;

   serial_bit_cmp u_bit_cmp (
      .a      (sa_q[0]),
      .b      (sb_q[0]),
      .bit_eq (bit_eq)
   );

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      found_d = found_q;
      eq_d    = eq_q;
      fd_d    = fd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sa_d    = bus.a_in;
               sb_d    = bus.b_in;
               cnt_d   = '0;
               acc_d   = 1'b1;
               found_d = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = acc_q & bit_eq;
            if (!bit_eq && !found_q) begin
               idx_d   = cnt_q;
               found_d = 1'b1;
            end
            sa_d = sa_q >> 1;
            sb_d = sb_q >> 1;
            // Counter parks on the last index so it never wraps.
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            eq_d    = acc_q;
            fd_d    = acc_q ? '0 : idx_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         acc_q   <= 1'b0;
         found_q <= 1'b0;
         eq_q    <= 1'b0;
         fd_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         found_q <= found_d;
         eq_q    <= eq_d;
         fd_q    <= fd_d;
         done_q  <= done_d;
      end
   end

   // The done pulse is registered together with eq so it marks the result as valid.
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.eq         = eq_q;
   assign bus.first_diff = fd_q;

endmodule

// File: tb/tb_serial_eq_comparator.sv
// Randomized scoreboard bench for serial_eq_comparator against a plain-arithmetic model.
module tb_serial_eq_comparator;
   localparam int WIDTH = 5;
   localparam int IDX_W = 3;

   typedef struct {
      logic             eq;
      logic [IDX_W-1:0] fd;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   inited = 1'b0;
   exp_t sb_q[$];

   logic             m_eq = 1'b0;
   logic [IDX_W-1:0] m_fd = '0;
   bit               pend_clr = 1'b0;

   serial_eq_comparator_if #(.WIDTH(WIDTH)) bus ();

   serial_eq_comparator #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: equality is plain ==, first_diff is the smallest i with a[i] != b[i].
   function automatic exp_t ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      e.eq  = (a == b);
      e.fd  = '0;
      e.cyc = 0;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (a[i] != b[i]) e.fd = IDX_W'(i);
      return e;
   endfunction

   // Monitor: pops on done, otherwise checks the result is held.
   always @(negedge clk) begin
      if (inited) begin
         if (!rst_n) begin
            pend_clr = 1'b1;
         end else begin
            if (pend_clr) begin
               m_eq = 1'b0;
               m_fd = '0;
               pend_clr = 1'b0;
            end
            if (bus.done) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_done", 32'(bus.done), 32'd0);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  chk("eq", 32'(bus.eq), 32'(e.eq));
                  chk("first_diff", 32'(bus.first_diff), 32'(e.fd));
                  chk("latency", 32'(cyc), 32'(e.cyc));
                  m_eq = e.eq;
                  m_fd = e.fd;
               end
            end else begin
               chk("eq_held", 32'(bus.eq), 32'(m_eq));
               chk("fd_held", 32'(bus.first_diff), 32'(m_fd));
            end
         end
      end
   end

   // Issue one compare from posedge+2 alignment; optionally pokes start while busy.
   task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
      exp_t e;
      int   nb;
      bit   got;
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      @(posedge clk);
      #1;
      e = ref_cmp(a, b);
      e.cyc = cyc + WIDTH + 1;
      sb_q.push_back(e);
      #1;
      bus.start = 1'b0;
      bus.a_in  = WIDTH'($urandom);
      bus.b_in  = WIDTH'($urandom);
      nb  = 0;
      got = 1'b0;
      for (int k = 0; k < WIDTH + 6; k++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            chk("busy_at_done", 32'(bus.busy), 32'd0);
            break;
         end
         if (bus.busy) nb++;
         @(posedge clk);
         #2;
         if (poke && k <= WIDTH - 1) begin
            bus.start = 1'b1;
            bus.a_in  = '1;
            bus.b_in  = '0;
         end else begin
            bus.start = 1'b0;
            bus.a_in  = WIDTH'($urandom);
            bus.b_in  = WIDTH'($urandom);
         end
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("busy_cycles", 32'(nb), 32'(WIDTH + 1));
      @(posedge clk);
      #2;
      bus.start = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.a_in  = '0;
      bus.b_in  = '0;
      repeat (3) @(posedge clk);
      #2;
      rst_n     = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_eq", 32'(bus.eq), 32'd0);
      chk("rst_fd", 32'(bus.first_diff), 32'd0);
      inited = 1'b1;
      @(posedge clk);
      #2;

      run_cmp(5'b00001, 5'b00001, 1'b0);
      run_cmp(5'b00101, 5'b00011, 1'b0);
      run_cmp(5'b11111, 5'b11111, 1'b0);
      run_cmp(5'b10101, 5'b01010, 1'b0);
      run_cmp(5'b10000, 5'b00000, 1'b0);
      run_cmp(5'b00001, 5'b00001, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      chk("busy_after_poke", 32'(bus.busy), 32'd0);

      // Reset in the third SHIFT cycle, after an eq=1 result is on the outputs.
      run_cmp(5'b11011, 5'b11011, 1'b0);
      bus.start = 1'b1;
      bus.a_in  = '1;
      bus.b_in  = '0;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_eq", 32'(bus.eq), 32'd0);
      chk("midrst_fd", 32'(bus.first_diff), 32'd0);
      repeat (WIDTH + 3) @(posedge clk);
      #2;
      run_cmp(5'b01010, 5'b01010, 1'b0);

      for (int n = 0; n < 150; n++) begin
         ra = WIDTH'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
         run_cmp(ra, rb, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            bus.a_in = WIDTH'($urandom);
            bus.b_in = WIDTH'($urandom);
            @(posedge clk);
            #2;
         end
      end

      repeat (4) @(posedge clk);
      chk("queue_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
